// File: rtl/game_pkg.sv
// game_pkg: screen geometry and sizing shared by the player and enemy controllers.
package game_pkg;
  localparam int SCREEN_W     = 640;
  localparam int SCREEN_H     = 480;
  localparam int SPRITE_SIZE  = 32;
  localparam int COORD_W      = 10;
  localparam int BULLET_COUNT = 8;

  typedef logic [COORD_W-1:0] coord_t;

  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/free_slot_finder.sv
// free_slot_finder: reports whether any slot is free and the lowest free index.
module free_slot_finder
  import game_pkg::*;
#(
  parameter int N = game_pkg::BULLET_COUNT
) (
  input  logic [N-1:0]          active_i,
  output logic                  found_o,
  output logic [idx_w(N)-1:0]   idx_o
);
  localparam int IW = idx_w(N);

  // Scanning downward lets the lowest free index overwrite higher ones.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = N - 1; i >= 0; i--)
      if (!active_i[i]) begin
        found_o = 1'b1;
        idx_o   = IW'(i);
      end
  end
endmodule

// File: rtl/player_bullet_controller.sv
// player_bullet_controller: synchronises the fire button, rate-limits shots and
// moves a fixed pool of player bullets upward on a periodic tick.
module player_bullet_controller
  import game_pkg::*;
#(
  parameter int BULLET_COUNT    = game_pkg::BULLET_COUNT,
  parameter int MOVE_PERIOD     = 131072,
  parameter int BULLET_SPEED    = 4,
  parameter int COOLDOWN_CYCLES = 2000000,
  parameter int X_OFFSET        = 14
) (
  input  logic                            clk25,
  input  logic                            rst_n,
  input  logic                            fire,
  input  logic [COORD_W-1:0]              player_x,
  input  logic [COORD_W-1:0]              player_y,
  input  logic [BULLET_COUNT-1:0]         bullet_hit,
  output logic [COORD_W*BULLET_COUNT-1:0] bullet_x_flat,
  output logic [COORD_W*BULLET_COUNT-1:0] bullet_y_flat,
  output logic [BULLET_COUNT-1:0]         bullet_active_flat,
  output logic                            shot_fired,
  output logic                            shot_dropped
);
  localparam int IW = idx_w(BULLET_COUNT);
  localparam int TW = idx_w(MOVE_PERIOD);
  localparam int CW = idx_w(COOLDOWN_CYCLES + 1);

  logic [2:0]                           sync_q;
  logic [TW-1:0]                        tick_q, tick_d;
  logic [CW-1:0]                        cool_q, cool_d;
  logic [BULLET_COUNT-1:0][COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [BULLET_COUNT-1:0]              active_q, active_d;
  logic                                 fired_q, dropped_q;
  logic                                 fire_edge, tick, accept, found;
  logic [IW-1:0]                        free_idx;

  free_slot_finder #(.N(BULLET_COUNT)) u_finder (
    .active_i (active_q),
    .found_o  (found),
    .idx_o    (free_idx)
  );

  // sync_q[1:0] is the metastability pair; sync_q[2] holds the previous level for edge detection.
  assign fire_edge = sync_q[1] & ~sync_q[2];
  assign tick      = tick_q == TW'(MOVE_PERIOD - 1);
  assign accept    = fire_edge && cool_q == '0 && found;
  assign tick_d    = tick ? '0 : tick_q + TW'(1);
  assign cool_d    = accept ? CW'(COOLDOWN_CYCLES - 1) : cool_q - CW'(cool_q != '0);

  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    active_d = active_q;
    for (int j = 0; j < BULLET_COUNT; j++)
      if (accept && free_idx == IW'(j)) begin
        x_d[j]      = player_x + COORD_W'(X_OFFSET);
        y_d[j]      = player_y;
        active_d[j] = 1'b1;
      end else if (active_q[j] && (bullet_hit[j] || tick)) begin
        active_d[j] = !bullet_hit[j] && y_q[j] >= COORD_W'(BULLET_SPEED);
        if (active_d[j]) y_d[j] = y_q[j] - COORD_W'(BULLET_SPEED);
      end
  end

  always_ff @(posedge clk25 or negedge rst_n)
    if (!rst_n) begin
      sync_q    <= '0;
      tick_q    <= '0;
      cool_q    <= '0;
      x_q       <= '0;
      y_q       <= '0;
      active_q  <= '0;
      fired_q   <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[1:0], fire};
      tick_q    <= tick_d;
      cool_q    <= cool_d;
      x_q       <= x_d;
      y_q       <= y_d;
      active_q  <= active_d;
      fired_q   <= accept;
      dropped_q <= fire_edge && !accept;
    end

  assign bullet_x_flat      = x_q;
  assign bullet_y_flat      = y_q;
  assign bullet_active_flat = active_q;
  assign shot_fired         = fired_q;
  assign shot_dropped       = dropped_q;
endmodule

// File: tb/tb_player_bullet_controller.sv
// tb_player_bullet_controller: table-driven shots, multi-cycle corner sequences and
// randomized traffic compared cycle by cycle against a behavioural model.
module tb_player_bullet_controller;
  localparam int N  = 8;
  localparam int MP = 4;
  localparam int SP = 4;
  localparam int CD = 100;
  localparam int XO = 14;

  logic           clk25 = 1'b0;
  logic           rst_n = 1'b0;
  logic           fire = 1'b0;
  logic [9:0]     player_x = '0;
  logic [9:0]     player_y = '0;
  logic [N-1:0]   bullet_hit = '0;
  logic [10*N-1:0] bullet_x_flat, bullet_y_flat;
  logic [N-1:0]   bullet_active_flat;
  logic           shot_fired, shot_dropped;
  int             checks = 0;
  int             failures = 0;
  logic           chk_en = 1'b0;

  player_bullet_controller #(
    .BULLET_COUNT(N), .MOVE_PERIOD(MP), .BULLET_SPEED(SP),
    .COOLDOWN_CYCLES(CD), .X_OFFSET(XO)
  ) dut (
    .clk25              (clk25),
    .rst_n              (rst_n),
    .fire               (fire),
    .player_x           (player_x),
    .player_y           (player_y),
    .bullet_hit         (bullet_hit),
    .bullet_x_flat      (bullet_x_flat),
    .bullet_y_flat      (bullet_y_flat),
    .bullet_active_flat (bullet_active_flat),
    .shot_fired         (shot_fired),
    .shot_dropped       (shot_dropped)
  );

  always #5 clk25 = ~clk25;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Behavioural model: shots are decided from the fire level seen two and three
  // samples ago, cooldown from the edge count since the last accepted shot.
  typedef struct {
    logic [N-1:0][9:0] x;
    logic [N-1:0][9:0] y;
    logic [N-1:0]      a;
    logic              f;
    logic              d;
    logic [2:0]        h;
    int                n;
    int                last;
  } mst_t;

  mst_t m;

  function automatic mst_t fresh();
    mst_t r;
    r.x = '0; r.y = '0; r.a = '0; r.f = 1'b0; r.d = 1'b0; r.h = '0; r.n = 0; r.last = -CD;
    return r;
  endfunction

  function automatic mst_t step(input mst_t s, input logic fi, input logic [N-1:0] hit,
                                input logic [9:0] px, input logic [9:0] py);
    mst_t r;
    int fr;
    logic edg, acc, tk;
    r = s;
    fr = -1;
    for (int j = N - 1; j >= 0; j--) if (!s.a[j]) fr = j;
    edg = s.h[1] && !s.h[2];
    acc = edg && (s.n - s.last >= CD) && fr >= 0;
    tk  = (s.n % MP) == MP - 1;
    for (int j = 0; j < N; j++)
      if (acc && j == fr) begin
        r.x[j] = 10'((int'(px) + XO) % 1024);
        r.y[j] = py;
        r.a[j] = 1'b1;
      end else if (s.a[j] && hit[j]) r.a[j] = 1'b0;
      else if (s.a[j] && tk) begin
        if (int'(s.y[j]) < SP) r.a[j] = 1'b0;
        else r.y[j] = 10'(int'(s.y[j]) - SP);
      end
    r.f = acc;
    r.d = edg && !acc;
    r.h = {s.h[1:0], fi};
    r.n = s.n + 1;
    if (acc) r.last = s.n;
    return r;
  endfunction

  always @(posedge clk25 or negedge rst_n)
    if (!rst_n) m <= fresh();
    else m <= step(m, fire, bullet_hit, player_x, player_y);

  always @(negedge clk25)
    if (chk_en) begin
      chk("lock_x", 80'(bullet_x_flat), 80'(m.x));
      chk("lock_y", 80'(bullet_y_flat), 80'(m.y));
      chk("lock_active", 80'(bullet_active_flat), 80'(m.a));
      chk("lock_fired", 80'(shot_fired), 80'(m.f));
      chk("lock_dropped", 80'(shot_dropped), 80'(m.d));
    end

  typedef struct {
    bit         rst;
    logic [9:0] px, py;
    int         gap;
    logic       ef, ed;
    int         slot;
    logic [9:0] ex, ey;
    logic [N-1:0] mask;
  } vec_t;

  task automatic do_reset();
    @(negedge clk25);
    rst_n = 1'b0; fire = 1'b0; bullet_hit = '0;
    repeat (2) @(negedge clk25);
    rst_n = 1'b1;
  endtask

  task automatic run(input vec_t v, input string tag);
    logic gf, gd;
    gf = 1'b0; gd = 1'b0;
    if (v.rst) do_reset();
    @(negedge clk25);
    player_x = v.px; player_y = v.py; fire = 1'b1;
    for (int i = 0; i < 8 && !(gf || gd); i++) begin
      @(negedge clk25);
      gf = shot_fired; gd = shot_dropped;
      if (i == 1) fire = 1'b0;
    end
    fire = 1'b0;
    chk({tag, "_fired"}, 80'(gf), 80'(v.ef));
    chk({tag, "_dropped"}, 80'(gd), 80'(v.ed));
    chk({tag, "_mask"}, 80'(bullet_active_flat), 80'(v.mask));
    if (v.ef) begin
      chk({tag, "_x"}, 80'(bullet_x_flat[v.slot*10 +: 10]), 80'(v.ex));
      chk({tag, "_y"}, 80'(bullet_y_flat[v.slot*10 +: 10]), 80'(v.ey));
    end
    @(negedge clk25);
    chk({tag, "_pulse_end"}, 80'({shot_fired, shot_dropped}), 80'(0));
    repeat (v.gap) @(negedge clk25);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[11];
    logic [9:0]  y3, y4, xa, ya, yb;
    logic [10:0] prev;
    logic [10:0] expv[3];
    logic [4:0]  fv;
    logic [N-1:0] aa;

    tbl[0]  = '{1'b1, 10'd300,  10'd440,  10, 1'b1, 1'b0, 0, 10'd314, 10'd440,  8'h01};
    tbl[1]  = '{1'b0, 10'd100,  10'd1000, 96, 1'b0, 1'b1, 0, 10'd0,   10'd0,    8'h01};
    tbl[2]  = '{1'b1, 10'd1015, 10'd1020, 96, 1'b1, 1'b0, 0, 10'd5,   10'd1020, 8'h01};
    tbl[3]  = '{1'b0, 10'd0,    10'd1020, 96, 1'b1, 1'b0, 1, 10'd14,  10'd1020, 8'h03};
    tbl[4]  = '{1'b0, 10'd100,  10'd1020, 96, 1'b1, 1'b0, 2, 10'd114, 10'd1020, 8'h07};
    tbl[5]  = '{1'b0, 10'd200,  10'd1020, 96, 1'b1, 1'b0, 3, 10'd214, 10'd1020, 8'h0F};
    tbl[6]  = '{1'b0, 10'd300,  10'd1020, 96, 1'b1, 1'b0, 4, 10'd314, 10'd1020, 8'h1F};
    tbl[7]  = '{1'b0, 10'd400,  10'd1020, 96, 1'b1, 1'b0, 5, 10'd414, 10'd1020, 8'h3F};
    tbl[8]  = '{1'b0, 10'd500,  10'd1020, 96, 1'b1, 1'b0, 6, 10'd514, 10'd1020, 8'h7F};
    tbl[9]  = '{1'b0, 10'd1010, 10'd1020, 96, 1'b1, 1'b0, 7, 10'd0,   10'd1020, 8'hFF};
    tbl[10] = '{1'b0, 10'd50,   10'd1020, 0,  1'b0, 1'b1, 0, 10'd0,   10'd0,    8'hFF};
    expv[0] = {1'b1, 10'd6};
    expv[1] = {1'b1, 10'd2};
    expv[2] = {1'b0, 10'd2};

    repeat (3) @(negedge clk25);
    chk("reset_x", 80'(bullet_x_flat), 80'(0));
    chk("reset_y", 80'(bullet_y_flat), 80'(0));
    chk("reset_active", 80'(bullet_active_flat), 80'(0));
    chk("reset_pulses", 80'({shot_fired, shot_dropped}), 80'(0));
    chk_en = 1'b1;
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) run(tbl[i], $sformatf("row%0d", i));

    // Hit on slot 3 coinciding with a movement tick.
    for (int i = 0; i < 2 * MP && (m.n % MP) != MP - 1; i++) @(negedge clk25);
    y3 = m.y[3];
    y4 = m.y[4];
    bullet_hit = 8'h08;
    @(negedge clk25);
    bullet_hit = '0;
    chk("hit_active3", 80'(bullet_active_flat[3]), 80'(0));
    chk("hit_y3_kept", 80'(bullet_y_flat[30 +: 10]), 80'(y3));
    chk("hit_y4_moved", 80'(bullet_y_flat[40 +: 10]), 80'(10'(y4 - 10'd4)));
    run('{1'b0, 10'd600, 10'd1000, 0, 1'b1, 1'b0, 3, 10'd614, 10'd1000, 8'hFF}, "refill3");

    // Top-edge exit: y 10 -> 6 -> 2 -> inactive.
    run('{1'b1, 10'd0, 10'd10, 0, 1'b1, 1'b0, 0, 10'd14, 10'd10, 8'h01}, "exit_spawn");
    prev = {1'b1, 10'd10};
    for (int k = 0; k < 3; k++) begin
      int w;
      w = 0;
      while ({bullet_active_flat[0], bullet_y_flat[9:0]} == prev && w < 3 * MP) begin
        @(negedge clk25);
        w++;
      end
      prev = {bullet_active_flat[0], bullet_y_flat[9:0]};
      chk($sformatf("exit_step%0d", k), 80'(prev), 80'(expv[k]));
    end

    // Asynchronous reset with five bullets in flight and fire held through release.
    do_reset();
    for (int i = 0; i < 5; i++)
      run('{1'b0, 10'(40 * i), 10'd1000, 96, 1'b1, 1'b0, i, 10'(40 * i + 14), 10'd1000,
            8'((1 << (i + 1)) - 1)}, $sformatf("fill%0d", i));
    @(posedge clk25);
    #2;
    rst_n = 1'b0; fire = 1'b1; player_x = 10'd500; player_y = 10'd700;
    #1;
    chk("async_x", 80'(bullet_x_flat), 80'(0));
    chk("async_y", 80'(bullet_y_flat), 80'(0));
    chk("async_active", 80'(bullet_active_flat), 80'(0));
    chk("async_pulses", 80'({shot_fired, shot_dropped}), 80'(0));
    @(posedge clk25);
    #2;
    rst_n = 1'b1;
    fv = '0; xa = '0; ya = '0; yb = '0; aa = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk25);
      fv[i] = shot_fired;
      if (i == 3) begin
        xa = bullet_x_flat[9:0];
        ya = bullet_y_flat[9:0];
        aa = bullet_active_flat;
      end
      if (i == 4) yb = bullet_y_flat[9:0];
    end
    fire = 1'b0;
    chk("release_fired_seq", 80'(fv), 80'(5'b01000));
    chk("release_active", 80'(aa), 80'(8'h01));
    chk("release_x", 80'(xa), 80'(10'd514));
    chk("release_y", 80'(ya), 80'(10'd700));
    chk("release_first_tick", 80'(yb), 80'(10'd696));

    // Randomized traffic, checked by the lockstep model.
    do_reset();
    repeat (3000) begin
      @(negedge clk25);
      if ($urandom_range(0, 5) == 0) fire = ~fire;
      bullet_hit = N'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 7) == 0) begin
        player_x = 10'($urandom);
        player_y = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 7)) : 10'($urandom);
      end
    end
    bullet_hit = '0;
    fire = 1'b0;
    @(negedge clk25);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
